// File: rtl/uart_rx.sv
// uart_rx -- serial UART receiver feeding the receive slot of the UART data
// register. Frames are 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB
// first, each bit sampled at its centre. Every correctly framed byte is
// presented zero-extended on data_o together with a one-cycle wr_o strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : an even-parity bit follows the data bits; a parity mismatch
//               sets parity_err_o and suppresses wr_o.
//   undefined : no parity bit, parity_err_o is constant 0.
//
// Parameters
//   CLK_PER_BIT : clk_i cycles per bit (>= 4)
//   W           : width of data_o (byte in [7:0], upper bits zero)
//
// Ports
//   clk_i        : system clock, all logic on posedge
//   rst_i        : asynchronous active-low reset
//   rx_i         : asynchronous serial line, idle high
//   data_o       : last valid received byte, zero-extended
//   wr_o         : one-cycle strobe, data_o holds a new valid byte
//   busy_o       : high while a frame is in progress
//   frame_err_o  : stop-bit status of the last completed frame
//   parity_err_o : parity status of the last completed frame

module uart_rx #(
    parameter int CLK_PER_BIT = 434,
    parameter int W           = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rx_i,
    output logic [W-1:0] data_o,
    output logic         wr_o,
    output logic         busy_o,
    output logic         frame_err_o,
    output logic         parity_err_o
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    state_t         state_q;
    logic           rx_meta_q;
    logic           rxs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]     idx_q;
    logic [2:0]     idx_d;
    logic [7:0]     shift_q;
    logic [W-1:0]   data_q;
    logic           wr_q;
    logic           frame_err_q;
    logic           parity_bad;

    assign cnt_d = cnt_q + CNT_W'(1);
    assign idx_d = idx_q + 3'd1;

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic perr_q;
    // Even parity: received parity bit plus data bits must have an even
    // number of ones.
    assign parity_bad   = par_q ^ (^shift_q);
    assign parity_err_o = perr_q;
`else
    assign parity_bad   = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            // Two-flop synchronizer; only rxs_q is used below.
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            wr_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end

                // Re-check the line half a bit in; a high level means the
                // falling edge was a glitch.
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        state_q <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs_q;
                        idx_q          <= idx_d;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        par_q   <= rxs_q;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                        perr_q <= parity_bad;
`endif
                        if (rxs_q) begin
                            frame_err_q <= 1'b0;
                            state_q     <= S_IDLE;
                            if (!parity_bad) begin
                                wr_q   <= 1'b1;
                                data_q <= W'(shift_q);
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // A line held low after a bad stop bit must go high again
                // before a new start edge can be recognised.
                S_BREAK: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_o      = data_q;
    assign wr_o        = wr_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int W   = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         rx_i = 1'b1;
    logic [W-1:0] data_o;
    logic         wr_o;
    logic         busy_o;
    logic         frame_err_o;
    logic         parity_err_o;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int bb_count    = 0;
    logic prev_wr   = 1'b0;
    logic [31:0] wr_log [$];

    uart_rx #(.CLK_PER_BIT(CPB), .W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .wr_o        (wr_o),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    // Strobe monitor: logs every delivered byte and catches back-to-back pulses.
    always @(negedge clk) begin
        if (wr_o) begin
            wr_count++;
            wr_log.push_back(data_o);
            $display("rx byte 0x%02h data_o=0x%08h t=%0t", data_o[7:0], data_o, $time);
            if (prev_wr) bb_count++;
        end
        prev_wr = wr_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        // Reset values
        rst_i = 1'b0;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  data_o,       32'h0);
        check("rst_wr",    32'(wr_o),         32'h0);
        check("rst_busy",  32'(busy_o),       32'h0);
        check("rst_ferr",  32'(frame_err_o),  32'h0);
        check("rst_perr",  32'(parity_err_o), 32'h0);
        rst_i = 1'b1;
        repeat (5) @(negedge clk);
        $display("txn: reset released");

        // Single byte 0xA5
        send_frame(8'hA5, 1'b1);
        $display("txn: sent 0xA5");
        check("a5_count", 32'(wr_count), 32'd1);
        check("a5_data",  data_o, 32'h0000_00A5);
        check("a5_ferr",  32'(frame_err_o), 32'h0);
        check("a5_perr",  32'(parity_err_o), 32'h0);
        check("a5_busy",  32'(busy_o), 32'h0);

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        $display("txn: sent 0x00,0xFF back-to-back");
        check("b2b_count", 32'(wr_count), 32'd3);
        check("b2b_first", wr_log[1], 32'h0000_0000);
        check("b2b_second", wr_log[2], 32'h0000_00FF);
        check("b2b_data", data_o, 32'h0000_00FF);
        send_bit(1'b1);

        // Glitch shorter than half a bit
        rx_i = 1'b0;
        repeat (5) @(negedge clk);
        check("gl_busy_hi", 32'(busy_o), 32'h1);
        rx_i = 1'b1;
        repeat (20) @(negedge clk);
        $display("txn: 5-cycle glitch");
        check("gl_busy_lo", 32'(busy_o), 32'h0);
        check("gl_count", 32'(wr_count), 32'd3);
        check("gl_data", data_o, 32'h0000_00FF);

        // Framing error: 0x3C with stop bit 0, line held low
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        $display("txn: sent 0x3C with bad stop bit");
        check("fe_ferr", 32'(frame_err_o), 32'h1);
        check("fe_busy", 32'(busy_o), 32'h1);
        check("fe_count", 32'(wr_count), 32'd3);
        check("fe_data", data_o, 32'h0000_00FF);
        send_bit(1'b1);
        check("fe_idle", 32'(busy_o), 32'h0);
        send_frame(8'h12, 1'b1);
        $display("txn: sent 0x12");
        check("fe_clr", 32'(frame_err_o), 32'h0);
        check("fe_next", data_o, 32'h0000_0012);
        check("fe_next_count", 32'(wr_count), 32'd4);
        send_bit(1'b1);

        // Reset mid-DATA of 0x55 (start, then bits 1,0,1)
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mr_busy", 32'(busy_o), 32'h1);
        rst_i = 1'b0;
        rx_i  = 1'b1;
        #1;
        $display("txn: reset mid-frame");
        check("mr_data", data_o, 32'h0);
        check("mr_busy_lo", 32'(busy_o), 32'h0);
        check("mr_ferr", 32'(frame_err_o), 32'h0);
        check("mr_wr", 32'(wr_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        send_bit(1'b1);
        send_frame(8'h81, 1'b1);
        $display("txn: sent 0x81");
        check("mr_count", 32'(wr_count), 32'd5);
        check("mr_after", data_o, 32'h0000_0081);
        send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        send_frame_par(8'h07, 1'b1);
        $display("txn: sent 0x07 parity 1");
        check("par_ok_count", 32'(wr_count), 32'd6);
        check("par_ok_data", data_o, 32'h0000_0007);
        check("par_ok_perr", 32'(parity_err_o), 32'h0);
        send_bit(1'b1);
        send_frame_par(8'h07, 1'b0);
        $display("txn: sent 0x07 parity 0");
        check("par_bad_perr", 32'(parity_err_o), 32'h1);
        check("par_bad_count", 32'(wr_count), 32'd6);
        check("par_bad_data", data_o, 32'h0000_0007);
        check("par_bad_ferr", 32'(frame_err_o), 32'h0);
`else
        check("perr_tied", 32'(parity_err_o), 32'h0);
`endif

        check("no_b2b_pulse", 32'(bb_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
